xcvr_rst_seq: RTL and testbench
===============================

Name: xcvr_rst_seq

Overview:
- Parametrised multi-channel transceiver reset sequencer for the 10G Ethernet/PTP datapath.
- Drives one powerdown per TX PLL, plus per-channel TX/RX analog and digital resets and ready flags, from PLL lock, CDR lock and calibration-busy status.
- Adds multiple channels and PLLs, programmable hold times and automatic recovery from loss of lock.
- Sits between the native PHY and the MAC/PCS reset domain.

Parameters:
- CHANNELS, 1, number of transceiver channels.
- PLLS, 1, number of TX PLLs.
- PLL_SEL_W, max(1,$clog2(PLLS)), width of each channel's PLL select field (derived).
- PLL_PD_CYC, 125, clock cycles pll_powerdown is held after reset release.
- TX_DIG_CYC, 20, cycles the selected pll_locked must be continuously high before tx_digitalreset release.
- RX_LTD_CYC, 500, cycles rx_is_lockedtodata must be continuously high before rx_digitalreset release.
- SYNC_STAGES, 3, synchroniser depth on every status input (minimum 2).

Ports:
- clock  in  1  free-running system clock.
- reset  in  1  asynchronous, active-low; asserted when 0.
- pll_powerdown  out  PLLS  per-PLL powerdown.
- pll_locked  in  PLLS  per-PLL lock; asynchronous.
- pll_select  in  CHANNELS*PLL_SEL_W  PLL index per channel; quasi-static.
- tx_cal_busy  in  CHANNELS  TX calibration busy; asynchronous.
- tx_analogreset  out  CHANNELS  per-channel TX analog reset.
- tx_digitalreset  out  CHANNELS  per-channel TX digital reset.
- tx_ready  out  CHANNELS  TX channel out of reset.
- rx_is_lockedtodata  in  CHANNELS  CDR lock; asynchronous.
- rx_cal_busy  in  CHANNELS  RX calibration busy; asynchronous.
- rx_analogreset  out  CHANNELS  per-channel RX analog reset.
- rx_digitalreset  out  CHANNELS  per-channel RX digital reset.
- rx_ready  out  CHANNELS  RX channel out of reset.

Behaviour:
- Reset state (reset=0, asynchronous):
  - pll_powerdown, all analog resets and all digital resets = all ones.
  - tx_ready, rx_ready = 0.
  - All counters and FSMs cleared.
- Synchronisation: every status input passes a SYNC_STAGES flop chain. All timings below are counted on synchronised values. All outputs are registered.
- PLL FSM (shared): PD, then RUN.
  - PD: pll_powerdown=1; counter runs PLL_PD_CYC cycles, then moves to RUN.
  - RUN: pll_powerdown=0; stays here until reset.
  - Reset is the only exit from RUN.
- TX FSM, per channel: TX_ANA, TX_LOCK, TX_RDY.
  - TX_ANA: analog=1, digital=1, ready=0. Leaves to TX_LOCK when PLL FSM is in RUN and tx_cal_busy=0.
  - TX_LOCK: analog=0, digital=1. A counter increments while pll_locked[pll_select[ch]]=1 and clears to 0 on any low cycle. Enters TX_RDY on the cycle the count reaches TX_DIG_CYC.
  - TX_RDY: digital=0, ready=1.
  - Loss of selected lock in TX_RDY: back to TX_LOCK; digital=1 and ready=0 on the next cycle.
  - tx_cal_busy=1 in any state: back to TX_ANA. This has priority over lock events in the same cycle.
  - pll_select >= PLLS is treated as unlocked.
- RX FSM, per channel: RX_ANA, RX_CDR, RX_RDY.
  - RX_ANA: analog=1, digital=1, ready=0. Leaves when rx_cal_busy=0.
  - RX_CDR: analog=0, digital=1. Consecutive-high counter on rx_is_lockedtodata; enters RX_RDY at RX_LTD_CYC.
  - RX_RDY: digital=0, ready=1.
  - Loss of CDR lock in RX_RDY: back to RX_CDR.
  - rx_cal_busy=1 in any state: back to RX_ANA.
  - RX is independent of the PLL FSM.
- Channels are fully independent; a fault on one channel never disturbs another.
- Counters saturate and never wrap. Counter width is $clog2(max cycle parameter + 1).
- Reset asserted mid-sequence: everything returns immediately to the reset state.

Optional Feature:
- Macro: XCVR_RST_MANUAL_EN.
- Defined: adds inputs tx_manual_rst[CHANNELS] and rx_manual_rst[CHANNELS], each synchronised. While a bit is high, that channel's FSM is forced into TX_ANA or RX_ANA respectively. Sequencing restarts when the bit falls.
- Undefined: these ports do not exist and the FSMs have no such path.

Decomposition:
- Package xcvr_rst_pkg holds:
  - enums pll_state_t {PD,RUN}, tx_state_t {TX_ANA,TX_LOCK,TX_RDY}, rx_state_t {RX_ANA,RX_CDR,RX_RDY};
  - function clog2_min1.
- Sub-module xcvr_rst_lane holds one channel's TX and RX FSMs and counters. It is instantiated CHANNELS times in a generate loop.
- The top level holds the synchronisers, the PLL FSM and the per-channel lock mux.

Test Plan (CHANNELS=2, PLLS=2, PLL_PD_CYC=8, TX_DIG_CYC=4, RX_LTD_CYC=16, SYNC_STAGES=2):
- Reset release, all locks high, cal_busy low: pll_powerdown falls 8 cycles after release; tx_ready rises about 2+4+1 cycles later; rx_ready rises about 2+16+1 cycles after release.
- Drop pll_locked[1] for 1 cycle while ch1 selects PLL1 and ch0 selects PLL0: ch1 tx_ready falls, then recovers 4 cycles after lock returns; ch0 is unaffected.
- Toggle rx_is_lockedtodata low every 10 cycles: rx_ready never asserts. Hold it high: rx_ready asserts after 16 consecutive cycles.
- tx_cal_busy[0] pulses high in TX_RDY: tx_analogreset[0]=1 and tx_ready[0]=0 within SYNC_STAGES+1 cycles; full TX re-sequence after it clears.
- Assert reset in TX_LOCK: all outputs return to reset values the same cycle (asynchronous).
- With XCVR_RST_MANUAL_EN: rx_manual_rst[1] held 5 cycles → rx_analogreset[1]=1; re-lock takes 16 cycles after release.

Source files
------------

// File: rtl/xcvr_rst_pkg.sv
// Shared types and helpers for the transceiver reset sequencer
// (xcvr_rst_seq, xcvr_rst_lane).
package xcvr_rst_pkg;

   typedef enum logic [0:0] {
      PD  = 1'b0,
      RUN = 1'b1
   } pll_state_t;

   typedef enum logic [1:0] {
      TX_ANA  = 2'd0,
      TX_LOCK = 2'd1,
      TX_RDY  = 2'd2
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_ANA = 2'd0,
      RX_CDR = 2'd1,
      RX_RDY = 2'd2
   } rx_state_t;

   // Bit width needed to index 'value' items, never less than one bit
   function automatic int clog2_min1(input int value);
      int w;
      w = $clog2(value);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/xcvr_rst_lane.sv
// One transceiver channel: TX and RX reset FSMs with consecutive-lock
// counters. All inputs arrive already synchronised. Outputs are registered
// from the next-state decode so they change on the same edge as the state.
// Optional build macro XCVR_RST_MANUAL_EN adds per-channel manual resets.
module xcvr_rst_lane
   import xcvr_rst_pkg::*;
#(
   parameter int TX_DIG_CYC = 20,
   parameter int RX_LTD_CYC = 500
) (
   input  logic clock,
   input  logic reset,
   input  logic pll_run,
   input  logic tx_cal_busy,
   input  logic tx_lock,
   input  logic rx_cal_busy,
   input  logic rx_lock,
`ifdef XCVR_RST_MANUAL_EN
   input  logic tx_manual_rst,
   input  logic rx_manual_rst,
`endif
   output logic tx_analogreset,
   output logic tx_digitalreset,
   output logic tx_ready,
   output logic rx_analogreset,
   output logic rx_digitalreset,
   output logic rx_ready
);

   localparam int              TX_W   = clog2_min1(TX_DIG_CYC + 1);
   localparam int              RX_W   = clog2_min1(RX_LTD_CYC + 1);
   localparam logic [TX_W-1:0] TX_MAX = TX_W'(TX_DIG_CYC);
   localparam logic [RX_W-1:0] RX_MAX = RX_W'(RX_LTD_CYC);
   localparam logic [TX_W-1:0] TX_ONE = TX_W'(1);
   localparam logic [RX_W-1:0] RX_ONE = RX_W'(1);

   tx_state_t       tx_state_r, tx_next_s;
   rx_state_t       rx_state_r, rx_next_s;
   logic [TX_W-1:0] tx_cnt_r, tx_cnt_next_s, tx_cnt_inc_s;
   logic [RX_W-1:0] rx_cnt_r, rx_cnt_next_s, rx_cnt_inc_s;
   logic            tx_force_s, rx_force_s;

`ifdef XCVR_RST_MANUAL_EN
   assign tx_force_s = tx_cal_busy | tx_manual_rst;
   assign rx_force_s = rx_cal_busy | rx_manual_rst;
`else
   assign tx_force_s = tx_cal_busy;
   assign rx_force_s = rx_cal_busy;
`endif

   // Saturating increments: counters hold at their limit rather than wrap
   assign tx_cnt_inc_s = (tx_cnt_r >= TX_MAX) ? tx_cnt_r : tx_cnt_r + TX_ONE;
   assign rx_cnt_inc_s = (rx_cnt_r >= RX_MAX) ? rx_cnt_r : rx_cnt_r + RX_ONE;

   // TX next state: calibration/manual reset wins over any lock event
   always_comb begin
      tx_next_s     = tx_state_r;
      tx_cnt_next_s = tx_cnt_r;
      if (tx_force_s) begin
         tx_next_s     = TX_ANA;
         tx_cnt_next_s = '0;
      end else begin
         case (tx_state_r)
            TX_ANA: begin
               tx_cnt_next_s = '0;
               if (pll_run) tx_next_s = TX_LOCK;
               else         tx_next_s = TX_ANA;
            end
            TX_LOCK: begin
               if (tx_lock) begin
                  tx_cnt_next_s = tx_cnt_inc_s;
                  if (tx_cnt_inc_s >= TX_MAX) tx_next_s = TX_RDY;
                  else                        tx_next_s = TX_LOCK;
               end else begin
                  tx_cnt_next_s = '0;
                  tx_next_s     = TX_LOCK;
               end
            end
            TX_RDY: begin
               if (tx_lock) begin
                  tx_next_s = TX_RDY;
               end else begin
                  tx_next_s     = TX_LOCK;
                  tx_cnt_next_s = '0;
               end
            end
            default: begin
               tx_next_s     = TX_ANA;
               tx_cnt_next_s = '0;
            end
         endcase
      end
   end

   // RX next state: independent of the PLLs, calibration/manual reset wins
   always_comb begin
      rx_next_s     = rx_state_r;
      rx_cnt_next_s = rx_cnt_r;
      if (rx_force_s) begin
         rx_next_s     = RX_ANA;
         rx_cnt_next_s = '0;
      end else begin
         case (rx_state_r)
            RX_ANA: begin
               rx_cnt_next_s = '0;
               rx_next_s     = RX_CDR;
            end
            RX_CDR: begin
               if (rx_lock) begin
                  rx_cnt_next_s = rx_cnt_inc_s;
                  if (rx_cnt_inc_s >= RX_MAX) rx_next_s = RX_RDY;
                  else                        rx_next_s = RX_CDR;
               end else begin
                  rx_cnt_next_s = '0;
                  rx_next_s     = RX_CDR;
               end
            end
            RX_RDY: begin
               if (rx_lock) begin
                  rx_next_s = RX_RDY;
               end else begin
                  rx_next_s     = RX_CDR;
                  rx_cnt_next_s = '0;
               end
            end
            default: begin
               rx_next_s     = RX_ANA;
               rx_cnt_next_s = '0;
            end
         endcase
      end
   end

   // TX state, counter and registered reset/ready outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_state_r      <= TX_ANA;
         tx_cnt_r        <= '0;
         tx_analogreset  <= 1'b1;
         tx_digitalreset <= 1'b1;
         tx_ready        <= 1'b0;
      end else begin
         tx_state_r      <= tx_next_s;
         tx_cnt_r        <= tx_cnt_next_s;
         tx_analogreset  <= (tx_next_s == TX_ANA);
         tx_digitalreset <= (tx_next_s != TX_RDY);
         tx_ready        <= (tx_next_s == TX_RDY);
      end
   end

   // RX state, counter and registered reset/ready outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_state_r      <= RX_ANA;
         rx_cnt_r        <= '0;
         rx_analogreset  <= 1'b1;
         rx_digitalreset <= 1'b1;
         rx_ready        <= 1'b0;
      end else begin
         rx_state_r      <= rx_next_s;
         rx_cnt_r        <= rx_cnt_next_s;
         rx_analogreset  <= (rx_next_s == RX_ANA);
         rx_digitalreset <= (rx_next_s != RX_RDY);
         rx_ready        <= (rx_next_s == RX_RDY);
      end
   end

endmodule

// File: rtl/xcvr_rst_seq.sv
// Multi-channel transceiver reset sequencer top: status synchronisers,
// shared PLL powerdown FSM, per-channel PLL lock select and lane instances.
// Optional build macro XCVR_RST_MANUAL_EN adds tx_manual_rst/rx_manual_rst.
module xcvr_rst_seq
   import xcvr_rst_pkg::*;
#(
   parameter int CHANNELS    = 1,
   parameter int PLLS        = 1,
   parameter int PLL_SEL_W   = clog2_min1(PLLS),
   parameter int PLL_PD_CYC  = 125,
   parameter int TX_DIG_CYC  = 20,
   parameter int RX_LTD_CYC  = 500,
   parameter int SYNC_STAGES = 3
) (
   input  logic                            clock,
   input  logic                            reset,
   output logic [PLLS-1:0]                 pll_powerdown,
   input  logic [PLLS-1:0]                 pll_locked,
   input  logic [CHANNELS*PLL_SEL_W-1:0]   pll_select,
   input  logic [CHANNELS-1:0]             tx_cal_busy,
   output logic [CHANNELS-1:0]             tx_analogreset,
   output logic [CHANNELS-1:0]             tx_digitalreset,
   output logic [CHANNELS-1:0]             tx_ready,
   input  logic [CHANNELS-1:0]             rx_is_lockedtodata,
   input  logic [CHANNELS-1:0]             rx_cal_busy,
`ifdef XCVR_RST_MANUAL_EN
   input  logic [CHANNELS-1:0]             tx_manual_rst,
   input  logic [CHANNELS-1:0]             rx_manual_rst,
`endif
   output logic [CHANNELS-1:0]             rx_analogreset,
   output logic [CHANNELS-1:0]             rx_digitalreset,
   output logic [CHANNELS-1:0]             rx_ready
);

   localparam int              PD_W    = clog2_min1(PLL_PD_CYC + 1);
   localparam logic [PD_W-1:0] PD_LAST = (PLL_PD_CYC > 0) ? PD_W'(PLL_PD_CYC - 1) : '0;
   localparam logic [PD_W-1:0] PD_ONE  = PD_W'(1);

   // Synchroniser chains; stage SYNC_STAGES-1 is the synchronised value
   logic [SYNC_STAGES-1:0][PLLS-1:0]     pll_lock_sync_r;
   logic [SYNC_STAGES-1:0][CHANNELS-1:0] tx_cal_sync_r;
   logic [SYNC_STAGES-1:0][CHANNELS-1:0] rx_cal_sync_r;
   logic [SYNC_STAGES-1:0][CHANNELS-1:0] rx_ltd_sync_r;
   logic [PLLS-1:0]                      pll_lock_s;
   logic [CHANNELS-1:0]                  tx_cal_s, rx_cal_s, rx_ltd_s;

   pll_state_t      pll_state_r;
   logic [PD_W-1:0] pd_cnt_r;
   logic            pd_r;
   logic            pll_run_s;

   // Status synchronisers; lock resets to unlocked and busy to busy so a
   // channel cannot run ahead of its real status while the chain fills
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pll_lock_sync_r <= '0;
         rx_ltd_sync_r   <= '0;
         tx_cal_sync_r   <= '1;
         rx_cal_sync_r   <= '1;
      end else begin
         pll_lock_sync_r <= {pll_lock_sync_r[SYNC_STAGES-2:0], pll_locked};
         rx_ltd_sync_r   <= {rx_ltd_sync_r[SYNC_STAGES-2:0], rx_is_lockedtodata};
         tx_cal_sync_r   <= {tx_cal_sync_r[SYNC_STAGES-2:0], tx_cal_busy};
         rx_cal_sync_r   <= {rx_cal_sync_r[SYNC_STAGES-2:0], rx_cal_busy};
      end
   end

   assign pll_lock_s = pll_lock_sync_r[SYNC_STAGES-1];
   assign tx_cal_s   = tx_cal_sync_r[SYNC_STAGES-1];
   assign rx_cal_s   = rx_cal_sync_r[SYNC_STAGES-1];
   assign rx_ltd_s   = rx_ltd_sync_r[SYNC_STAGES-1];

`ifdef XCVR_RST_MANUAL_EN
   logic [SYNC_STAGES-1:0][CHANNELS-1:0] tx_man_sync_r;
   logic [SYNC_STAGES-1:0][CHANNELS-1:0] rx_man_sync_r;
   logic [CHANNELS-1:0]                  tx_man_s, rx_man_s;

   // Manual reset synchronisers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_man_sync_r <= '0;
         rx_man_sync_r <= '0;
      end else begin
         tx_man_sync_r <= {tx_man_sync_r[SYNC_STAGES-2:0], tx_manual_rst};
         rx_man_sync_r <= {rx_man_sync_r[SYNC_STAGES-2:0], rx_manual_rst};
      end
   end

   assign tx_man_s = tx_man_sync_r[SYNC_STAGES-1];
   assign rx_man_s = rx_man_sync_r[SYNC_STAGES-1];
`endif

   // Shared PLL FSM: hold powerdown for PLL_PD_CYC cycles, then run until reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pll_state_r <= PD;
         pd_cnt_r    <= '0;
         pd_r        <= 1'b1;
      end else begin
         case (pll_state_r)
            PD: begin
               if (pd_cnt_r >= PD_LAST) begin
                  pll_state_r <= RUN;
                  pd_r        <= 1'b0;
               end else begin
                  pd_cnt_r    <= pd_cnt_r + PD_ONE;
                  pd_r        <= 1'b1;
               end
            end
            RUN: begin
               pll_state_r <= RUN;
               pd_r        <= 1'b0;
            end
            default: begin
               pll_state_r <= PD;
               pd_cnt_r    <= '0;
               pd_r        <= 1'b1;
            end
         endcase
      end
   end

   assign pll_run_s     = (pll_state_r == RUN);
   assign pll_powerdown = {PLLS{pd_r}};

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
      logic [PLL_SEL_W-1:0] sel_s;
      logic                 lock_s;

      assign sel_s = pll_select[ch*PLL_SEL_W +: PLL_SEL_W];

      // Route the selected PLL's lock; an out-of-range select reads as unlocked
      always_comb begin
         lock_s = 1'b0;
         if ({{(32-PLL_SEL_W){1'b0}}, sel_s} < 32'(PLLS)) begin
            lock_s = pll_lock_s[sel_s];
         end else begin
            lock_s = 1'b0;
         end
      end

      xcvr_rst_lane #(
         .TX_DIG_CYC (TX_DIG_CYC),
         .RX_LTD_CYC (RX_LTD_CYC)
      ) u_lane (
         .clock           (clock),
         .reset           (reset),
         .pll_run         (pll_run_s),
         .tx_cal_busy     (tx_cal_s[ch]),
         .tx_lock         (lock_s),
         .rx_cal_busy     (rx_cal_s[ch]),
         .rx_lock         (rx_ltd_s[ch]),
`ifdef XCVR_RST_MANUAL_EN
         .tx_manual_rst   (tx_man_s[ch]),
         .rx_manual_rst   (rx_man_s[ch]),
`endif
         .tx_analogreset  (tx_analogreset[ch]),
         .tx_digitalreset (tx_digitalreset[ch]),
         .tx_ready        (tx_ready[ch]),
         .rx_analogreset  (rx_analogreset[ch]),
         .rx_digitalreset (rx_digitalreset[ch]),
         .rx_ready        (rx_ready[ch])
      );
   end

endmodule

// File: tb/tb_xcvr_rst_seq.sv
// Directed bench for xcvr_rst_seq: 2 channels, 2 PLLs, short hold times.
// Edge numbers in comments count rising edges after the inputs were changed
// (inputs are driven 1 ns after a rising edge, outputs sampled there too).
module tb_xcvr_rst_seq;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] pll_powerdown;
   logic [1:0] pll_locked;
   logic [1:0] pll_select;
   logic [1:0] tx_cal_busy;
   logic [1:0] tx_analogreset;
   logic [1:0] tx_digitalreset;
   logic [1:0] tx_ready;
   logic [1:0] rx_is_lockedtodata;
   logic [1:0] rx_cal_busy;
   logic [1:0] rx_analogreset;
   logic [1:0] rx_digitalreset;
   logic [1:0] rx_ready;
`ifdef XCVR_RST_MANUAL_EN
   logic [1:0] tx_manual_rst;
   logic [1:0] rx_manual_rst;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   xcvr_rst_seq #(
      .CHANNELS    (2),
      .PLLS        (2),
      .PLL_PD_CYC  (8),
      .TX_DIG_CYC  (4),
      .RX_LTD_CYC  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .pll_powerdown      (pll_powerdown),
      .pll_locked         (pll_locked),
      .pll_select         (pll_select),
      .tx_cal_busy        (tx_cal_busy),
      .tx_analogreset     (tx_analogreset),
      .tx_digitalreset    (tx_digitalreset),
      .tx_ready           (tx_ready),
      .rx_is_lockedtodata (rx_is_lockedtodata),
      .rx_cal_busy        (rx_cal_busy),
`ifdef XCVR_RST_MANUAL_EN
      .tx_manual_rst      (tx_manual_rst),
      .rx_manual_rst      (rx_manual_rst),
`endif
      .rx_analogreset     (rx_analogreset),
      .rx_digitalreset    (rx_digitalreset),
      .rx_ready           (rx_ready)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, " pll_powerdown"},   32'(pll_powerdown),   32'h3);
      check_eq({tag, " tx_analogreset"},  32'(tx_analogreset),  32'h3);
      check_eq({tag, " tx_digitalreset"}, 32'(tx_digitalreset), 32'h3);
      check_eq({tag, " tx_ready"},        32'(tx_ready),        32'h0);
      check_eq({tag, " rx_analogreset"},  32'(rx_analogreset),  32'h3);
      check_eq({tag, " rx_digitalreset"}, 32'(rx_digitalreset), 32'h3);
      check_eq({tag, " rx_ready"},        32'(rx_ready),        32'h0);
   endtask

   initial begin
      reset              = 1'b0;
      pll_locked         = 2'b11;
      pll_select         = 2'b10;   // ch1 -> PLL1, ch0 -> PLL0
      tx_cal_busy        = 2'b00;
      rx_is_lockedtodata = 2'b11;
      rx_cal_busy        = 2'b00;
`ifdef XCVR_RST_MANUAL_EN
      tx_manual_rst      = 2'b00;
      rx_manual_rst      = 2'b00;
`endif
      step(3);
      check_reset_outputs("rst");

      // ---- power-up sequence: edges counted from reset release
      reset = 1'b1;
      step(2);   // e2: busy sync still filling
      check_eq("up rx_ana e2", 32'(rx_analogreset), 32'h3);
      step(1);   // e3: RX leaves analog reset
      check_eq("up rx_ana e3", 32'(rx_analogreset), 32'h0);
      check_eq("up rx_dig e3", 32'(rx_digitalreset), 32'h3);
      step(4);   // e7: powerdown still held
      check_eq("up pd e7", 32'(pll_powerdown), 32'h3);
      check_eq("up tx_ana e7", 32'(tx_analogreset), 32'h3);
      step(1);   // e8: PLL FSM enters RUN
      check_eq("up pd e8", 32'(pll_powerdown), 32'h0);
      check_eq("up tx_ana e8", 32'(tx_analogreset), 32'h3);
      step(1);   // e9: TX leaves analog reset
      check_eq("up tx_ana e9", 32'(tx_analogreset), 32'h0);
      check_eq("up tx_dig e9", 32'(tx_digitalreset), 32'h3);
      step(3);   // e12: lock count at 3
      check_eq("up tx_rdy e12", 32'(tx_ready), 32'h0);
      step(1);   // e13: lock count reaches 4
      check_eq("up tx_rdy e13", 32'(tx_ready), 32'h3);
      check_eq("up tx_dig e13", 32'(tx_digitalreset), 32'h0);
      step(5);   // e18: CDR count at 15
      check_eq("up rx_rdy e18", 32'(rx_ready), 32'h0);
      step(1);   // e19: CDR count reaches 16
      check_eq("up rx_rdy e19", 32'(rx_ready), 32'h3);
      check_eq("up rx_dig e19", 32'(rx_digitalreset), 32'h0);

      // ---- one-cycle drop of PLL1 lock: only ch1 reacts, seen at edge 3
      pll_locked = 2'b01;
      step(1);
      pll_locked = 2'b11;
      step(1);
      check_eq("pll1 drop tx_rdy +2", 32'(tx_ready), 32'h3);
      step(1);
      check_eq("pll1 drop tx_rdy +3", 32'(tx_ready), 32'h1);
      check_eq("pll1 drop tx_dig +3", 32'(tx_digitalreset), 32'h2);
      check_eq("pll1 drop tx_ana +3", 32'(tx_analogreset), 32'h0);
      step(3);
      check_eq("pll1 drop tx_rdy +6", 32'(tx_ready), 32'h1);
      step(1);
      check_eq("pll1 drop tx_rdy +7", 32'(tx_ready), 32'h3);
      check_eq("pll1 drop rx_rdy", 32'(rx_ready), 32'h3);

      // ---- CDR lock drops every 10 cycles: count never reaches 16
      for (int i = 0; i < 6; i++) begin
         rx_is_lockedtodata = 2'b00;
         step(1);
         rx_is_lockedtodata = 2'b11;
         step(9);
         check_eq($sformatf("cdr toggle rx_rdy %0d", i), 32'(rx_ready), 32'h0);
         check_eq($sformatf("cdr toggle rx_dig %0d", i), 32'(rx_digitalreset), 32'h3);
      end
      check_eq("cdr toggle tx_rdy", 32'(tx_ready), 32'h3);
      step(8);   // 18 edges after last drop: count at 15
      check_eq("cdr hold rx_rdy +18", 32'(rx_ready), 32'h0);
      step(1);   // 19 edges: count reaches 16
      check_eq("cdr hold rx_rdy +19", 32'(rx_ready), 32'h3);

      // ---- tx_cal_busy[0] pulse in TX_RDY: full TX re-sequence on ch0
      tx_cal_busy = 2'b01;
      step(1);
      tx_cal_busy = 2'b00;
      step(1);
      check_eq("txcal tx_rdy +2", 32'(tx_ready), 32'h3);
      step(1);
      check_eq("txcal tx_ana +3", 32'(tx_analogreset), 32'h1);
      check_eq("txcal tx_rdy +3", 32'(tx_ready), 32'h2);
      step(1);
      check_eq("txcal tx_ana +4", 32'(tx_analogreset), 32'h0);
      check_eq("txcal tx_rdy +4", 32'(tx_ready), 32'h2);
      step(3);
      check_eq("txcal tx_rdy +7", 32'(tx_ready), 32'h2);
      step(1);
      check_eq("txcal tx_rdy +8", 32'(tx_ready), 32'h3);
      check_eq("txcal rx_rdy", 32'(rx_ready), 32'h3);

`ifdef XCVR_RST_MANUAL_EN
      // ---- rx_manual_rst[1] held for 5 cycles
      rx_manual_rst = 2'b10;
      step(3);
      check_eq("man rx_ana +3", 32'(rx_analogreset), 32'h2);
      check_eq("man rx_rdy +3", 32'(rx_ready), 32'h1);
      step(2);
      rx_manual_rst = 2'b00;
      step(2);
      check_eq("man rx_ana +7", 32'(rx_analogreset), 32'h2);
      step(1);
      check_eq("man rx_ana +8", 32'(rx_analogreset), 32'h0);
      step(15);
      check_eq("man rx_rdy +23", 32'(rx_ready), 32'h1);
      step(1);
      check_eq("man rx_rdy +24", 32'(rx_ready), 32'h3);
`endif

      // ---- reset asserted while ch0 is in TX_LOCK
      pll_locked = 2'b10;
      step(1);
      pll_locked = 2'b11;
      step(2);
      check_eq("midrst tx_rdy pre", 32'(tx_ready), 32'h2);
      step(1);
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      step(2);
      reset = 1'b1;
      step(7);
      check_eq("rerun pd e7", 32'(pll_powerdown), 32'h3);
      step(1);
      check_eq("rerun pd e8", 32'(pll_powerdown), 32'h0);
      check_eq("rerun tx_rdy e8", 32'(tx_ready), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
